// File: rtl/message_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// message_tx_sequencer_if
//   Event handshake bus between the run-control/sensor logic (master) and the
//   message_tx_sequencer (slave).
//
//   evt_valid  master->slave  1  event present this cycle (single-cycle strobe)
//   evt_type   master->slave  2  0 fault, 1 pickup, 2 deposit, 3 end-of-run
//   evt_unit   master->slave  2  1 E, 2 C, 3 R; 0 invalid
//   evt_su_id  master->slave  3  sub-unit 1..4; other values invalid
//   evt_block  master->slave  2  block 0..3 -> B1..B4
//   evt_ready  slave->master  1  event FIFO not full
// ---------------------------------------------------------------------------
interface message_tx_sequencer_if;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [1:0] evt_unit;
    logic [2:0] evt_su_id;
    logic [1:0] evt_block;
    logic       evt_ready;

    modport master (
        output evt_valid, evt_type, evt_unit, evt_su_id, evt_block,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_type, evt_unit, evt_su_id, evt_block,
        output evt_ready
    );
endinterface

// File: rtl/message_tx_sequencer.sv
// ---------------------------------------------------------------------------
// message_tx_sequencer
//   Queued status-message generator for the UART TX path. Typed event records
//   are buffered in a small FIFO, each one is expanded into its ASCII string
//   (FIM-XSUn-#, BPM-SU-Bn-#, BDM-XSUn-Bn-#, END-#) and the bytes are paced one
//   per BAUD_DIV clocks towards uart_tx.
//
//   Parameters
//     BAUD_DIV  clk_50M cycles per byte slot (>=16)
//     QDEPTH    event FIFO depth, power of two, 2..16
//     CNT_W     width of drop_count
//
//   Ports
//     clk_50M     in   system clock, 50 MHz
//     rst_n       in   asynchronous active-low reset
//     evt         if   event handshake (slave modport of message_tx_sequencer_if)
//     node_flag   in   node reached; clears the dedup history when enabled
//     tx_byte     out  ASCII byte of the current slot (0 outside a slot)
//     tx_start    out  1-cycle pulse at the start of each byte slot
//     busy        out  message being serialised or FIFO non-empty
//     drop_count  out  events lost to FIFO full, saturating
//
//   Build option
//     MSG_DEDUP_EN  when defined, an accepted event identical to the previous
//                   accepted event is silently discarded until node_flag is
//                   seen; end-of-run events are never discarded.
// ---------------------------------------------------------------------------
module message_tx_sequencer #(
    parameter int BAUD_DIV = 4340,
    parameter int QDEPTH   = 4,
    parameter int CNT_W    = 8
) (
    input  logic                  clk_50M,
    input  logic                  rst_n,
    message_tx_sequencer_if.slave evt,
    input  logic                  node_flag,
    output logic [7:0]            tx_byte,
    output logic                  tx_start,
    output logic                  busy,
    output logic [CNT_W-1:0]      drop_count
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(QDEPTH);
    localparam logic [CW-1:0] SLOT_LAST = CW'(BAUD_DIV - 1);

    typedef struct packed {
        logic [1:0] typ;
        logic [1:0] unit;
        logic [2:0] su;
        logic [1:0] blk;
    } evt_rec_t;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} state_t;

    state_t          state_reg, state_next;
    evt_rec_t        fifo_mem [QDEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg, count_next;
    logic [CNT_W-1:0] drop_count_reg;
    evt_rec_t        rec_reg;
    logic [3:0]      idx_reg;
    logic [CW-1:0]   slot_cnt_reg;

    evt_rec_t        in_rec;
    logic            fifo_full, fifo_empty;
    logic            pop, room, push, drop, is_dup;
    logic            slot_last;
    logic [7:0]      cur_byte, unit_ch, su_ch, blk_ch;

    assign in_rec     = '{typ: evt.evt_type, unit: evt.evt_unit,
                          su: evt.evt_su_id, blk: evt.evt_block};
    assign fifo_full  = (count_reg == FULL_CNT);
    assign fifo_empty = (count_reg == '0);
    assign pop        = (state_reg == ST_LOAD);
    // A pop in the same cycle frees a slot, so a write on a full FIFO is
    // still accepted then.
    assign room       = !fifo_full || pop;
    assign push       = evt.evt_valid && room && !is_dup;
    assign drop       = evt.evt_valid && !room;
    assign evt.evt_ready = !fifo_full;

`ifdef MSG_DEDUP_EN
    evt_rec_t last_reg;
    logic     last_valid_reg;

    // node_flag in the same cycle clears history first, so the event is kept.
    assign is_dup = evt.evt_valid && room && last_valid_reg && !node_flag &&
                    (in_rec == last_reg) && (in_rec.typ != 2'd3);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            last_reg       <= '0;
            last_valid_reg <= 1'b0;
        end else begin
            if (node_flag)
                last_valid_reg <= 1'b0;
            if (push) begin
                last_reg       <= in_rec;
                last_valid_reg <= 1'b1;
            end
        end
    end
`else
    logic unused_node_flag;
    assign unused_node_flag = node_flag;
    assign is_dup           = 1'b0;
`endif

    // Event storage: plain array with a registered read into rec_reg.
    always_ff @(posedge clk_50M) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= in_rec;
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            drop_count_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            if (drop && (drop_count_reg != '1))
                drop_count_reg <= drop_count_reg + 1'b1;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // ---------------- FSM: next state ----------------
    // A push in the current cycle counts as "FIFO non-empty": the record is
    // written at this edge and LOAD reads it one cycle later.
    assign slot_last = (slot_cnt_reg == SLOT_LAST);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (!fifo_empty || push) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_SEND;
            ST_SEND: if (slot_last && (cur_byte == 8'h23))
                         state_next = (!fifo_empty || push) ? ST_LOAD : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath: held record, byte index, slot counter ----------
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rec_reg      <= '0;
            idx_reg      <= '0;
            slot_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    rec_reg      <= fifo_mem[rd_ptr_reg];
                    idx_reg      <= '0;
                    slot_cnt_reg <= '0;
                end
                ST_SEND: begin
                    if (slot_last) begin
                        slot_cnt_reg <= '0;
                        idx_reg      <= idx_reg + 1'b1;
                    end else begin
                        slot_cnt_reg <= slot_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    slot_cnt_reg <= '0;
                end
            endcase
        end
    end

    // ---------------- message byte table ----------------
    always_comb begin
        unit_ch = "?";
        case (rec_reg.unit)
            2'd1:    unit_ch = "E";
            2'd2:    unit_ch = "C";
            2'd3:    unit_ch = "R";
            default: unit_ch = "?";
        endcase
        su_ch  = ((rec_reg.su >= 3'd1) && (rec_reg.su <= 3'd4)) ?
                 (8'h30 + {5'd0, rec_reg.su}) : "?";
        blk_ch = 8'h31 + {6'd0, rec_reg.blk};
    end

    // Any index past the end of a string reads '#', so a message always ends.
    always_comb begin
        cur_byte = "#";
        case (rec_reg.typ)
            2'd0: case (idx_reg)        // FIM-USUn-#
                4'd0: cur_byte = "F";     4'd1: cur_byte = "I";
                4'd2: cur_byte = "M";     4'd3: cur_byte = "-";
                4'd4: cur_byte = unit_ch; 4'd5: cur_byte = "S";
                4'd6: cur_byte = "U";     4'd7: cur_byte = su_ch;
                4'd8: cur_byte = "-";     default: cur_byte = "#";
            endcase
            2'd1: case (idx_reg)        // BPM-SU-Bb-#
                4'd0: cur_byte = "B";     4'd1: cur_byte = "P";
                4'd2: cur_byte = "M";     4'd3: cur_byte = "-";
                4'd4: cur_byte = "S";     4'd5: cur_byte = "U";
                4'd6: cur_byte = "-";     4'd7: cur_byte = "B";
                4'd8: cur_byte = blk_ch;  4'd9: cur_byte = "-";
                default: cur_byte = "#";
            endcase
            2'd2: case (idx_reg)        // BDM-USUn-Bb-#
                4'd0:  cur_byte = "B";     4'd1:  cur_byte = "D";
                4'd2:  cur_byte = "M";     4'd3:  cur_byte = "-";
                4'd4:  cur_byte = unit_ch; 4'd5:  cur_byte = "S";
                4'd6:  cur_byte = "U";     4'd7:  cur_byte = su_ch;
                4'd8:  cur_byte = "-";     4'd9:  cur_byte = "B";
                4'd10: cur_byte = blk_ch;  4'd11: cur_byte = "-";
                default: cur_byte = "#";
            endcase
            default: case (idx_reg)     // END-#
                4'd0: cur_byte = "E";     4'd1: cur_byte = "N";
                4'd2: cur_byte = "D";     4'd3: cur_byte = "-";
                default: cur_byte = "#";
            endcase
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        tx_start = 1'b0;
        tx_byte  = 8'h00;
        if (state_reg == ST_SEND) begin
            tx_start = (slot_cnt_reg == '0);
            tx_byte  = cur_byte;
        end
        busy = (state_reg != ST_IDLE) || !fifo_empty;
    end

    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_message_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_message_tx_sequencer
//   Directed bench for message_tx_sequencer with BAUD_DIV=16, QDEPTH=4.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
//   Expected byte strings and cycle positions are written out by hand.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_message_tx_sequencer;
    localparam int BAUD   = 16;
    localparam int QDEPTH = 4;
    localparam int CNT_W  = 8;

    logic             clk_50M = 1'b0;
    logic             rst_n;
    logic             node_flag;
    logic [7:0]       tx_byte;
    logic             tx_start;
    logic             busy;
    logic [CNT_W-1:0] drop_count;

    int n_vec  = 0;
    int n_miss = 0;

    message_tx_sequencer_if ev_if ();

    message_tx_sequencer #(.BAUD_DIV(BAUD), .QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .evt        (ev_if),
        .node_flag  (node_flag),
        .tx_byte    (tx_byte),
        .tx_start   (tx_start),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #10 clk_50M = ~clk_50M;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    // One-cycle strobe; returns one cycle later (the cycle after the strobe).
    task automatic send_evt(input logic [1:0] t, input logic [1:0] u,
                            input logic [2:0] s, input logic [1:0] b);
        ev_if.evt_valid = 1'b1;
        ev_if.evt_type  = t;
        ev_if.evt_unit  = u;
        ev_if.evt_su_id = s;
        ev_if.evt_block = b;
        tick();
        ev_if.evt_valid = 1'b0;
    endtask

    // Called at cycle first_c of the first byte slot; checks every slot and
    // returns in the cycle right after the final slot.
    task automatic check_msg(input string name, input string s, input int first_c);
        for (int i = 0; i < s.len(); i++) begin
            int bad = 0;
            int c0  = (i == 0) ? first_c : 0;
            for (int c = c0; c < BAUD; c++) begin
                if (c == c0) begin
                    chk($sformatf("%s_byte[%0d]", name, i), tx_byte, s[i]);
                    if (c == 0)
                        chk($sformatf("%s_start[%0d]", name, i), tx_start, 1);
                end else if (tx_start !== 1'b0 || tx_byte !== s[i]) begin
                    bad++;
                end
                tick();
            end
            chk($sformatf("%s_hold[%0d]", name, i), bad, 0);
        end
    endtask

    // The single LOAD cycle between back-to-back messages.
    task automatic load_gap(input string name);
        chk({name, "_gap_start"}, tx_start, 0);
        chk({name, "_gap_busy"}, busy, 1);
        tick();
    endtask

    initial begin
        rst_n           = 1'b0;
        node_flag       = 1'b0;
        ev_if.evt_valid = 1'b0;
        ev_if.evt_type  = '0;
        ev_if.evt_unit  = '0;
        ev_if.evt_su_id = '0;
        ev_if.evt_block = '0;
        tick();
        tick();
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ev_if.evt_ready, 1);
        chk("rst_drop", drop_count, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // 1: fault E/2, first tx_start two cycles after the strobe
        send_evt(2'd0, 2'd1, 3'd2, 2'd0);
        chk("t1_lat_start", tx_start, 0);
        chk("t1_lat_busy", busy, 1);
        tick();
        check_msg("t1", "FIM-ESU2-#", 0);
        chk("t1_idle_busy", busy, 0);
        tick();

        // 2: deposit R/4/B2 then end, back-to-back
        send_evt(2'd2, 2'd3, 3'd4, 2'd1);
        send_evt(2'd3, 2'd0, 3'd0, 2'd0);
        check_msg("t2a", "BDM-RSU4-B2-#", 0);
        load_gap("t2");
        check_msg("t2b", "END-#", 0);
        chk("t2_idle_busy", busy, 0);
        tick();

        // 3: overflow - one message in flight, QDEPTH+2 strobes while sending
        send_evt(2'd0, 2'd1, 3'd1, 2'd0);
        tick();
        send_evt(2'd1, 2'd1, 3'd1, 2'd2);
        send_evt(2'd3, 2'd0, 3'd0, 2'd0);
        send_evt(2'd0, 2'd2, 3'd3, 2'd0);
        chk("t3_ready_3q", ev_if.evt_ready, 1);
        send_evt(2'd2, 2'd1, 3'd1, 2'd3);
        chk("t3_ready_full", ev_if.evt_ready, 0);
        send_evt(2'd3, 2'd0, 3'd0, 2'd0);
        send_evt(2'd3, 2'd0, 3'd0, 2'd0);
        chk("t3_drop", drop_count, 2);
        check_msg("t3a", "FIM-ESU1-#", 6);
        load_gap("t3a");
        check_msg("t3b", "BPM-SU-B3-#", 0);
        load_gap("t3b");
        check_msg("t3c", "END-#", 0);
        load_gap("t3c");
        check_msg("t3d", "FIM-CSU3-#", 0);
        load_gap("t3d");
        check_msg("t3e", "BDM-ESU1-B4-#", 0);
        chk("t3_idle_busy", busy, 0);
        chk("t3_idle_ready", ev_if.evt_ready, 1);
        tick();

        // 4: invalid unit and sub-unit render as '?'
        send_evt(2'd0, 2'd0, 3'd7, 2'd0);
        tick();
        check_msg("t4", "FIM-?SU?-#", 0);
        chk("t4_idle_busy", busy, 0);
        tick();

        // 5: reset at slot 5 of a pickup with one more event queued
        send_evt(2'd1, 2'd1, 3'd1, 2'd0);
        send_evt(2'd3, 2'd0, 3'd0, 2'd0);
        for (int k = 0; k < 5 * BAUD; k++) tick();
        chk("t5_slot5_start", tx_start, 1);
        chk("t5_slot5_byte", tx_byte, "U");
        rst_n = 1'b0;
        #1;
        chk("t5_rst_start", tx_start, 0);
        chk("t5_rst_byte", tx_byte, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_drop", drop_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t5_post_busy", busy, 0);
        chk("t5_post_start", tx_start, 0);
        chk("t5_post_ready", ev_if.evt_ready, 1);
        send_evt(2'd0, 2'd2, 3'd1, 2'd0);
        tick();
        check_msg("t5", "FIM-CSU1-#", 0);
        chk("t5_idle_busy", busy, 0);
        tick();

        // 6: same pickup twice, then node_flag and repeat
        send_evt(2'd1, 2'd1, 3'd1, 2'd0);
        send_evt(2'd1, 2'd1, 3'd1, 2'd0);
        check_msg("t6a", "BPM-SU-B1-#", 0);
`ifdef MSG_DEDUP_EN
        chk("t6_dedup_busy", busy, 0);
        tick();
        tick();
        chk("t6_dedup_start", tx_start, 0);
        node_flag = 1'b1;
        tick();
        node_flag = 1'b0;
        send_evt(2'd1, 2'd1, 3'd1, 2'd0);
        tick();
        check_msg("t6b", "BPM-SU-B1-#", 0);
`else
        load_gap("t6");
        check_msg("t6b", "BPM-SU-B1-#", 0);
`endif
        chk("t6_idle_busy", busy, 0);
        chk("t6_drop", drop_count, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
